address_datapath: RTL and testbench

- Consumer of the address FSM's control word `{pc_out, pc_inc, ldlo, ldhi}`; owns the program counter and the effective-address (EA) latch.
- Drives the 16-bit memory address bus and applies X/Y indexing, including the page-cross fix-up cycle.
- Sits between `address_fsm` (control) and the memory/data bus in the v6502 core; its stall output back-pressures the FSM.

---
 rtl/address_datapath_pkg.sv | 40 ++++
 rtl/address_datapath.sv | 138 +++++++++++++
 tb/tb_address_datapath.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/address_datapath_pkg.sv
// Shared definitions for the v6502 address path: control-word bit positions,
// addressing-mode codes, datapath state encoding and the index-select helper.
// Imported by address_datapath and by the address FSM that drives it.
package address_datapath_pkg;

  // Bit positions inside the {pc_out, pc_inc, ldlo, ldhi} control word.
  localparam int CTRL_PC_OUT = 3;
  localparam int CTRL_PC_INC = 2;
  localparam int CTRL_LDLO   = 1;
  localparam int CTRL_LDHI   = 0;
  localparam int CTRL_W      = 4;

  // Addressing-mode codes used by the address FSM.
  localparam logic [3:0] ADDR_MODE_IMP  = 4'd0;
  localparam logic [3:0] ADDR_MODE_IMM  = 4'd1;
  localparam logic [3:0] ADDR_MODE_ZP   = 4'd2;
  localparam logic [3:0] ADDR_MODE_ZPX  = 4'd3;
  localparam logic [3:0] ADDR_MODE_ZPY  = 4'd4;
  localparam logic [3:0] ADDR_MODE_ABS  = 4'd5;
  localparam logic [3:0] ADDR_MODE_ABSX = 4'd6;
  localparam logic [3:0] ADDR_MODE_ABSY = 4'd7;

  // Datapath state: normal operation, or the single page-cross fix-up cycle.
  typedef enum logic {
    IDLE  = 1'b0,
    FIXUP = 1'b1
  } state_t;

  // Index byte applied to the EA: X or Y when indexing, otherwise zero.
  function automatic logic [7:0] idx_select(input logic       index_en,
                                            input logic       index_reg,
                                            input logic [7:0] x,
                                            input logic [7:0] y);
    if (!index_en) begin
      return 8'h00;
    end
    return index_reg ? y : x;
  endfunction

endpackage

// File: rtl/address_datapath.sv
// Program counter, effective-address latch and X/Y indexing for the v6502 core.
// Latency: o_addr combinational; PC/EA registered one cycle after the control word.
// Backpressure: a low-byte carry on ldhi inserts one FIXUP cycle with o_stall high.
module address_datapath
  import address_datapath_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'hFFFC
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [7:0]        i_data,
  input  logic              i_index_en,
  input  logic              i_index_reg,
  input  logic [7:0]        i_x,
  input  logic [7:0]        i_y,
  input  logic              i_zp,
  input  logic              i_pc_load,
  input  logic [15:0]       i_pc_val,
  output logic [15:0]       o_addr,
  output logic [15:0]       o_pc,
  output logic [15:0]       o_ea,
  output logic              o_ea_valid,
  output logic              o_page_cross,
  output logic              o_stall
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc;
  logic [15:0] pc_nxt;
  logic [7:0]  ea_lo;
  logic [7:0]  ea_lo_nxt;
  logic [7:0]  ea_hi;
  logic [7:0]  ea_hi_nxt;
  logic        ea_valid;
  logic        ea_valid_nxt;
  logic        page_cross;
  logic        page_cross_nxt;

  logic        pc_out;
  logic        pc_inc;
  logic        ldlo;
  logic        ldhi;
  logic [7:0]  idx;
  logic [8:0]  idx_sum;
  logic [7:0]  zp_lo;

  assign pc_out = i_ctrl[CTRL_PC_OUT];
  assign pc_inc = i_ctrl[CTRL_PC_INC];
  assign ldlo   = i_ctrl[CTRL_LDLO];
  assign ldhi   = i_ctrl[CTRL_LDHI];

  assign idx     = idx_select(i_index_en, i_index_reg, i_x, i_y);
  // Carry out of bit 7 is the page-cross indicator for absolute,X/Y.
  assign idx_sum = {1'b0, ea_lo} + {1'b0, idx};
  // Zero-page indexing wraps inside page 0, so the carry is simply dropped.
  assign zp_lo   = i_data + (i_zp ? idx : 8'h00);

  // Address bus: zero-latency mux so opcode/immediate fetches need no extra cycle.
  // During FIXUP ea_hi is still uncorrected, which yields the 6502 dummy read.
  assign o_addr       = pc_out ? pc : {ea_hi, ea_lo};
  assign o_pc         = pc;
  assign o_ea         = {ea_hi, ea_lo};
  assign o_ea_valid   = ea_valid;
  assign o_page_cross = page_cross;
  assign o_stall      = (state == FIXUP);

  // State and datapath registers; reset drops any in-flight fix-up.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ea_lo      <= 8'h00;
      ea_hi      <= 8'h00;
      ea_valid   <= 1'b0;
      page_cross <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ea_lo      <= ea_lo_nxt;
      ea_hi      <= ea_hi_nxt;
      ea_valid   <= ea_valid_nxt;
      page_cross <= page_cross_nxt;
    end
  end

  // Next-state and next-datapath values; everything holds unless updated.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    ea_lo_nxt      = ea_lo;
    ea_hi_nxt      = ea_hi;
    ea_valid_nxt   = ea_valid;
    page_cross_nxt = page_cross;

    case (state)
      IDLE: begin
        // Jumps and vector loads beat the sequential increment.
        if (i_pc_load) begin
          pc_nxt = i_pc_val;
        end else if (pc_inc) begin
          pc_nxt = pc + 16'd1;
        end

        // ldhi wins if the FSM ever asserts both strobes.
        if (ldhi) begin
          ea_lo_nxt = idx_sum[7:0];
          ea_hi_nxt = i_data;
          if (idx_sum[8]) begin
            ea_valid_nxt   = 1'b0;
            page_cross_nxt = 1'b1;
            state_nxt      = FIXUP;
          end else begin
            ea_valid_nxt   = 1'b1;
            page_cross_nxt = 1'b0;
          end
        end else if (ldlo) begin
          ea_lo_nxt      = zp_lo;
          ea_hi_nxt      = 8'h00;
          ea_valid_nxt   = i_zp;
          page_cross_nxt = 1'b0;
        end
      end

      default: begin
        // FIXUP: propagate the carry into the high byte; only pc_load is honoured.
        if (i_pc_load) begin
          pc_nxt = i_pc_val;
        end
        ea_hi_nxt    = ea_hi + 8'd1;
        ea_valid_nxt = 1'b1;
        state_nxt    = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_address_datapath.sv
// Directed self-checking bench for address_datapath.
// Inputs change #1 after posedge; outputs checked #1 after the following posedge.
// Each task drives one scenario and compares against hand-computed values.
module tb_address_datapath;

  logic        i_clk;
  logic        i_rst;
  logic [3:0]  i_ctrl;
  logic [7:0]  i_data;
  logic        i_index_en;
  logic        i_index_reg;
  logic [7:0]  i_x;
  logic [7:0]  i_y;
  logic        i_zp;
  logic        i_pc_load;
  logic [15:0] i_pc_val;
  logic [15:0] o_addr;
  logic [15:0] o_pc;
  logic [15:0] o_ea;
  logic        o_ea_valid;
  logic        o_page_cross;
  logic        o_stall;

  int n_cmp;
  int n_bad;

  address_datapath #(.RESET_PC(16'hFFFC)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ctrl       (i_ctrl),
    .i_data       (i_data),
    .i_index_en   (i_index_en),
    .i_index_reg  (i_index_reg),
    .i_x          (i_x),
    .i_y          (i_y),
    .i_zp         (i_zp),
    .i_pc_load    (i_pc_load),
    .i_pc_val     (i_pc_val),
    .o_addr       (o_addr),
    .o_pc         (o_pc),
    .o_ea         (o_ea),
    .o_ea_valid   (o_ea_valid),
    .o_page_cross (o_page_cross),
    .o_stall      (o_stall)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_ctrl      = 4'b0000;
    i_data      = 8'h00;
    i_index_en  = 1'b0;
    i_index_reg = 1'b0;
    i_x         = 8'h00;
    i_y         = 8'h00;
    i_zp        = 1'b0;
    i_pc_load   = 1'b0;
    i_pc_val    = 16'h0000;
  endtask

  task automatic load_pc(input logic [15:0] v);
    i_pc_load = 1'b1;
    i_pc_val  = v;
    tick();
    i_pc_load = 1'b0;
  endtask

  task automatic test_reset();
    load_pc(16'h1234);
    i_ctrl = 4'b1000;
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if (o_pc !== 16'hFFFC) begin n_bad++; $display("FAIL reset_pc got %h want %h", o_pc, 16'hFFFC); end
    n_cmp++;
    if (o_addr !== 16'hFFFC) begin n_bad++; $display("FAIL reset_addr got %h want %h", o_addr, 16'hFFFC); end
    n_cmp++;
    if (o_ea_valid !== 1'b0 || o_stall !== 1'b0 || o_page_cross !== 1'b0 || o_ea !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_flags got valid=%b stall=%b cross=%b ea=%h want 0 0 0 0000",
               o_ea_valid, o_stall, o_page_cross, o_ea);
    end
    tick();
    i_rst = 1'b0;
    i_ctrl = 4'b0000;
    tick();
  endtask

  task automatic test_immediate();
    load_pc(16'h0200);
    i_ctrl = 4'b1000;
    #1;
    n_cmp++;
    if (o_addr !== 16'h0200) begin n_bad++; $display("FAIL imm_addr got %h want %h", o_addr, 16'h0200); end
    tick();
    n_cmp++;
    if (o_pc !== 16'h0200) begin n_bad++; $display("FAIL imm_pc_hold got %h want %h", o_pc, 16'h0200); end
    i_ctrl = 4'b1100;
    tick();
    n_cmp++;
    if (o_pc !== 16'h0201) begin n_bad++; $display("FAIL imm_pc_inc got %h want %h", o_pc, 16'h0201); end
    i_ctrl = 4'b0000;
  endtask

  task automatic test_absolute();
    load_pc(16'h0300);
    i_ctrl = 4'b1110; i_data = 8'h34;
    tick();
    n_cmp++;
    if (o_ea_valid !== 1'b0) begin n_bad++; $display("FAIL abs_lo_valid got %b want 0", o_ea_valid); end
    i_ctrl = 4'b1101; i_data = 8'h12;
    tick();
    i_ctrl = 4'b0000; i_data = 8'h00;
    #1;
    n_cmp++;
    if (o_ea !== 16'h1234 || o_ea_valid !== 1'b1) begin
      n_bad++; $display("FAIL abs_ea got %h/%b want 1234/1", o_ea, o_ea_valid);
    end
    n_cmp++;
    if (o_pc !== 16'h0302) begin n_bad++; $display("FAIL abs_pc got %h want %h", o_pc, 16'h0302); end
    n_cmp++;
    if (o_addr !== 16'h1234) begin n_bad++; $display("FAIL abs_addr_ea got %h want %h", o_addr, 16'h1234); end
    // pc-only cycle: EA and valid must hold
    i_ctrl = 4'b1100;
    tick();
    n_cmp++;
    if (o_ea !== 16'h1234 || o_ea_valid !== 1'b1 || o_pc !== 16'h0303) begin
      n_bad++; $display("FAIL abs_hold got ea=%h v=%b pc=%h want 1234 1 0303", o_ea, o_ea_valid, o_pc);
    end
    i_ctrl = 4'b0000;
  endtask

  task automatic test_abs_x_cross();
    load_pc(16'h0400);
    i_index_en = 1'b1; i_index_reg = 1'b0; i_x = 8'h10; i_y = 8'h77;
    i_ctrl = 4'b1110; i_data = 8'hF8;
    tick();
    i_ctrl = 4'b1101; i_data = 8'h12;
    tick();
    // FIXUP cycle: strobes must be ignored
    i_ctrl = 4'b0111; i_data = 8'hAA;
    #1;
    n_cmp++;
    if (o_ea !== 16'h1208 || o_stall !== 1'b1 || o_page_cross !== 1'b1 || o_ea_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL absx_cross got ea=%h st=%b pc=%b v=%b want 1208 1 1 0",
               o_ea, o_stall, o_page_cross, o_ea_valid);
    end
    n_cmp++;
    if (o_addr !== 16'h1208) begin n_bad++; $display("FAIL absx_dummy_addr got %h want %h", o_addr, 16'h1208); end
    tick();
    i_ctrl = 4'b0000;
    #1;
    n_cmp++;
    if (o_ea !== 16'h1308 || o_ea_valid !== 1'b1 || o_stall !== 1'b0) begin
      n_bad++; $display("FAIL absx_fixup got ea=%h v=%b st=%b want 1308 1 0", o_ea, o_ea_valid, o_stall);
    end
    n_cmp++;
    if (o_pc !== 16'h0402 || o_page_cross !== 1'b1) begin
      n_bad++; $display("FAIL absx_fixup_pc got pc=%h cross=%b want 0402 1", o_pc, o_page_cross);
    end
    idle_inputs();
  endtask

  task automatic test_abs_y();
    i_index_en = 1'b1; i_index_reg = 1'b1; i_x = 8'hF0; i_y = 8'h02;
    i_ctrl = 4'b0010; i_data = 8'h10;
    tick();
    i_ctrl = 4'b0001; i_data = 8'h40;
    tick();
    i_ctrl = 4'b0000;
    n_cmp++;
    if (o_ea !== 16'h4012 || o_stall !== 1'b0 || o_page_cross !== 1'b0 || o_ea_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL absy got ea=%h st=%b cross=%b v=%b want 4012 0 0 1",
               o_ea, o_stall, o_page_cross, o_ea_valid);
    end
    idle_inputs();
  endtask

  task automatic test_zp_wrap();
    i_zp = 1'b1; i_index_en = 1'b1; i_index_reg = 1'b0; i_x = 8'h02;
    i_ctrl = 4'b0010; i_data = 8'hFF;
    tick();
    i_ctrl = 4'b0000;
    n_cmp++;
    if (o_ea !== 16'h0001 || o_ea_valid !== 1'b1) begin
      n_bad++; $display("FAIL zpx_wrap got ea=%h v=%b want 0001 1", o_ea, o_ea_valid);
    end
    idle_inputs();
  endtask

  task automatic test_ldlo_ldhi_both();
    // ea_lo is 01 from the zp test; ldhi with no index wins over ldlo
    i_ctrl = 4'b0011; i_data = 8'h56;
    tick();
    i_ctrl = 4'b0000;
    n_cmp++;
    if (o_ea !== 16'h5601 || o_ea_valid !== 1'b1) begin
      n_bad++; $display("FAIL both_strobes got ea=%h v=%b want 5601 1", o_ea, o_ea_valid);
    end
    // plain non-zp ldlo clears valid and zeroes the high byte
    i_ctrl = 4'b0010; i_data = 8'h9A;
    tick();
    i_ctrl = 4'b0000;
    n_cmp++;
    if (o_ea !== 16'h009A || o_ea_valid !== 1'b0) begin
      n_bad++; $display("FAIL ldlo_clear got ea=%h v=%b want 009a 0", o_ea, o_ea_valid);
    end
  endtask

  task automatic test_pc_wrap();
    load_pc(16'hFFFF);
    i_ctrl = 4'b0100;
    tick();
    n_cmp++;
    if (o_pc !== 16'h0000) begin n_bad++; $display("FAIL pc_wrap got %h want %h", o_pc, 16'h0000); end
    i_pc_load = 1'b1; i_pc_val = 16'h8000;
    tick();
    i_pc_load = 1'b0; i_ctrl = 4'b0000;
    n_cmp++;
    if (o_pc !== 16'h8000) begin n_bad++; $display("FAIL pc_load_prio got %h want %h", o_pc, 16'h8000); end
  endtask

  task automatic test_fixup_pc_load();
    i_index_en = 1'b1; i_x = 8'hFF;
    i_ctrl = 4'b0010; i_data = 8'h01;
    tick();
    i_ctrl = 4'b0001; i_data = 8'hFF;
    tick();
    // in FIXUP: pc_load honoured, ea_hi wraps FF -> 00
    i_ctrl = 4'b0100; i_pc_load = 1'b1; i_pc_val = 16'hC000;
    tick();
    i_ctrl = 4'b0000; i_pc_load = 1'b0;
    n_cmp++;
    if (o_pc !== 16'hC000 || o_ea !== 16'h0000 || o_ea_valid !== 1'b1) begin
      n_bad++; $display("FAIL fixup_load_wrap got pc=%h ea=%h v=%b want c000 0000 1", o_pc, o_ea, o_ea_valid);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_fixup();
    i_index_en = 1'b1; i_x = 8'h80;
    i_ctrl = 4'b0010; i_data = 8'h90;
    tick();
    i_ctrl = 4'b0001; i_data = 8'h20;
    tick();
    i_ctrl = 4'b0000;
    n_cmp++;
    if (o_stall !== 1'b1) begin n_bad++; $display("FAIL rstfix_pre got stall=%b want 1", o_stall); end
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if (o_stall !== 1'b0 || o_ea !== 16'h0000 || o_pc !== 16'hFFFC || o_page_cross !== 1'b0 || o_ea_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rstfix got st=%b ea=%h pc=%h cross=%b v=%b want 0 0000 fffc 0 0",
               o_stall, o_ea, o_pc, o_page_cross, o_ea_valid);
    end
    tick();
    i_rst = 1'b0;
    idle_inputs();
    tick();
    n_cmp++;
    if (o_ea !== 16'h0000 || o_stall !== 1'b0) begin
      n_bad++; $display("FAIL rstfix_release got ea=%h st=%b want 0000 0", o_ea, o_stall);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    i_rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    i_rst = 1'b0;
    tick();
    test_reset();
    test_immediate();
    test_absolute();
    test_abs_x_cross();
    test_abs_y();
    test_zp_wrap();
    test_ldlo_ldhi_both();
    test_pc_wrap();
    test_fixup_pc_load();
    test_reset_mid_fixup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
